mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit in the EXE stage. Executes MULT/MULTU/DIV/DIVU and produces the HI/LO result pair.
- Drives the mul/div busy signal that the pipeline write/flush control consumes. While busy is high, the control unit stalls PC, IF/ID and ID/EXE.
- Honours exception flush and holds its result across cache-induced pipeline stalls until the instruction leaves EXE.

Parameters:
- DATA_WIDTH, 32, operand width; HI and LO are each DATA_WIDTH bits.
- CNT_WIDTH, 6, width of the divide iteration counter; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  EXE holds a mult/div instruction; stays stable until pipe_adv
- op_is_div  in  1  1 = divide, 0 = multiply
- op_signed  in  1  1 = signed (MULT/DIV), 0 = unsigned
- src_a  in  DATA_WIDTH  rs operand (multiplicand/dividend)
- src_b  in  DATA_WIDTH  rt operand (multiplier/divisor)
- flush  in  1  exception flush of EXE (EXE/MEM exception flush)
- pipe_adv  in  1  EXE instruction advances this cycle (EXE/MEM write enable high and no stall)
- busy  out  1  mul/div busy to the write/flush control; 1 = stall upstream
- res_valid  out  1  HI/LO result valid for the instruction currently in EXE
- res_hi  out  DATA_WIDTH  HI result (product high / remainder)
- res_lo  out  DATA_WIDTH  LO result (product low / quotient)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, counter=0, res_hi=0, res_lo=0, res_valid=0. busy=0 whenever op_valid=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start condition: op_valid=1 and flush=0 starts an operation.
  - Latch the operand absolute values, the signs and the op type.
  - Next state is DIV if op_is_div=1, otherwise MUL.
- MUL: one cycle. Registers the full 2*DATA_WIDTH product, corrected for sign when op_signed=1. Next state is DONE.
- DIV: restoring radix-2 division on absolute values, one quotient bit per cycle for DATA_WIDTH cycles. When the counter reaches DATA_WIDTH-1, apply the sign fix and go to DONE.
- DONE: res_valid=1 and res_hi/res_lo held stable.
  - pipe_adv=1 goes to IDLE, with res_valid=0 in the next cycle.
  - pipe_adv=0, e.g. during a cache stall, holds DONE indefinitely.
- busy (combinational):
  - busy = ((IDLE & op_valid) | MUL | DIV) & ~flush.
  - busy is 0 in DONE, which lets ID/EXE proceed.
  - The unit never restarts the same instruction: leaving DONE requires pipe_adv.
- Latency, counted from the first cycle op_valid is seen in IDLE (T0):
  - Multiply: busy high T0–T1, res_valid at T2.
  - Divide: busy high T0 through T(DATA_WIDTH), res_valid at T(DATA_WIDTH+1) = T33.
- Sign rules for signed ops:
  - Product is negated if sa^sb.
  - Quotient is negated if sa^sb.
  - Remainder takes the sign of the dividend.
- Divide by zero (no trap): LO=all ones, HI=src_a. This is deterministic and identical for signed and unsigned.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- flush in any state: next state IDLE, res_valid=0, counter=0, and busy is forced 0 in the same cycle. flush has priority over pipe_adv and over start.
- rst mid-operation: IDLE next cycle, all outputs return to their reset values.
- Back-to-back ops: DONE with pipe_adv=1 goes to IDLE, and the new op_valid starts in the following cycle. This adds one bubble-free IDLE cycle, during which busy is already high.
- Operands change while MUL/DIV is in progress: this is a protocol violation. The latched values are used and the result is unaffected.
- Arithmetic uses DATA_WIDTH+1-bit partial remainders. There is no truncation before the final sign fix.

Test Plan:
- MULT signed: src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> busy 2 cycles, then res_valid=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU: src_a=100, src_b=7 -> busy for exactly 33 cycles, then res_valid=1, LO=14, HI=2. Stays held while pipe_adv=0 for 5 cycles, then res_valid=0 one cycle after pipe_adv=1.
- DIV signed: src_a=-7 (0xFFFFFFF9), src_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678, latency 33.
- Flush at divide iteration 10 -> busy=0 the same cycle, state IDLE next cycle, no res_valid. A new MULTU 5*6 issued afterwards gives LO=30, HI=0 with normal latency.
- rst asserted mid-divide -> next cycle busy=0, res_valid=0, res_hi=res_lo=0.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// ----------------------------------------------------------------------------
// mdu_iterative_if
// Handshake/result bundle between the EXE stage and the iterative
// multiply/divide unit.
//   master : EXE-stage side. Drives the operation request, operands, the
//            exception flush and pipe advance. Receives busy and the HI/LO
//            result.
//   slave  : multiply/divide unit side.
// ----------------------------------------------------------------------------
interface mdu_iterative_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  op_valid;   // EXE holds a mult/div instruction
   logic                  op_is_div;  // 1 = divide, 0 = multiply
   logic                  op_signed;  // 1 = MULT/DIV, 0 = MULTU/DIVU
   logic [DATA_WIDTH-1:0] src_a;      // rs: multiplicand / dividend
   logic [DATA_WIDTH-1:0] src_b;      // rt: multiplier / divisor
   logic                  flush;      // exception flush of EXE
   logic                  pipe_adv;   // EXE instruction advances this cycle
   logic                  busy;       // stall request to the pipeline control
   logic                  res_valid;  // HI/LO valid for the EXE instruction
   logic [DATA_WIDTH-1:0] res_hi;     // product high / remainder
   logic [DATA_WIDTH-1:0] res_lo;     // product low / quotient

   modport master (
      output op_valid, op_is_div, op_signed, src_a, src_b, flush, pipe_adv,
      input  busy, res_valid, res_hi, res_lo
   );

   modport slave (
      input  op_valid, op_is_div, op_signed, src_a, src_b, flush, pipe_adv,
      output busy, res_valid, res_hi, res_lo
   );
endinterface : mdu_iterative_if

// File: rtl/mdu_iterative.sv
// ----------------------------------------------------------------------------
// mdu_iterative
// Multi-cycle multiply/divide unit for the EXE stage (MULT/MULTU/DIV/DIVU).
// Multiply completes in one working cycle; divide is restoring radix-2, one
// quotient bit per cycle. The result is held in DONE until the instruction
// leaves EXE (pipe_adv), so cache stalls do not lose it. An exception flush
// aborts any operation immediately.
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : mdu_iterative_if.slave (request, operands, flush, pipe_adv,
//          busy, res_valid, res_hi, res_lo)
// ----------------------------------------------------------------------------
module mdu_iterative #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic              clk,
   input  logic              rst,
   mdu_iterative_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] D_ZERO   = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] D_ONES   = {DATA_WIDTH{1'b1}};

   // Two's-complement negate when neg is set (single width)
   function automatic logic [DATA_WIDTH-1:0] cond_neg(
      input logic [DATA_WIDTH-1:0] v,
      input logic                  neg
   );
      logic [DATA_WIDTH-1:0] r;
      if (neg) begin
         r = (~v) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Two's-complement negate when neg is set (double width, for products)
   function automatic logic [2*DATA_WIDTH-1:0] cond_neg2(
      input logic [2*DATA_WIDTH-1:0] v,
      input logic                    neg
   );
      logic [2*DATA_WIDTH-1:0] r;
      if (neg) begin
         r = (~v) + {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] a_abs_q, a_abs_d;   // |dividend| / |multiplicand|
   logic [DATA_WIDTH-1:0] b_abs_q, b_abs_d;   // |divisor|  / |multiplier|
   logic                  sa_q, sa_d;         // operand signs, 0 for unsigned ops
   logic                  sb_q, sb_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;       // settled partial remainder (< divisor)
   logic [DATA_WIDTH-1:0] quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic                  valid_q, valid_d;

   logic                    start_sa_s;
   logic                    start_sb_s;
   logic [2*DATA_WIDTH-1:0] prod_abs_s;
   logic [2*DATA_WIDTH-1:0] prod_s;
   logic [DATA_WIDTH:0]     trial_s;          // DATA_WIDTH+1-bit trial remainder
   logic [DATA_WIDTH:0]     diff_s;
   logic                    q_bit_s;
   logic [DATA_WIDTH-1:0]   rem_next_s;
   logic [DATA_WIDTH-1:0]   quo_next_s;

   assign start_sa_s = bus.op_signed & bus.src_a[DATA_WIDTH-1];
   assign start_sb_s = bus.op_signed & bus.src_b[DATA_WIDTH-1];

   assign prod_abs_s = {D_ZERO, a_abs_q} * {D_ZERO, b_abs_q};
   assign prod_s     = cond_neg2(prod_abs_s, sa_q ^ sb_q);

   // Restoring step: since rem_q < divisor, trial - divisor always fits in
   // DATA_WIDTH+1 bits as a signed value, so its MSB is the borrow.
   assign trial_s    = {rem_q, quo_q[DATA_WIDTH-1]};
   assign diff_s     = trial_s - {1'b0, b_abs_q};
   assign q_bit_s    = ~diff_s[DATA_WIDTH];
   assign rem_next_s = q_bit_s ? diff_s[DATA_WIDTH-1:0] : trial_s[DATA_WIDTH-1:0];
   assign quo_next_s = {quo_q[DATA_WIDTH-2:0], q_bit_s};

   assign bus.busy      = (((state_q == S_IDLE) & bus.op_valid) |
                           (state_q == S_MUL) | (state_q == S_DIV)) & ~bus.flush;
   assign bus.res_valid = valid_q;
   assign bus.res_hi    = hi_q;
   assign bus.res_lo    = lo_q;

   // Next-state and datapath update; flush overrides everything else
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_abs_d = a_abs_q;
      b_abs_d = b_abs_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      valid_d = valid_q;

      if (bus.flush) begin
         state_d = S_IDLE;
         cnt_d   = CNT_ZERO;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.op_valid) begin
                  sa_d    = start_sa_s;
                  sb_d    = start_sb_s;
                  a_abs_d = cond_neg(bus.src_a, start_sa_s);
                  b_abs_d = cond_neg(bus.src_b, start_sb_s);
                  rem_d   = D_ZERO;
                  quo_d   = cond_neg(bus.src_a, start_sa_s);
                  cnt_d   = CNT_ZERO;
                  state_d = bus.op_is_div ? S_DIV : S_MUL;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MUL: begin
               hi_d    = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
               lo_d    = prod_s[DATA_WIDTH-1:0];
               valid_d = 1'b1;
               state_d = S_DONE;
            end
            S_DIV: begin
               rem_d = rem_next_s;
               quo_d = quo_next_s;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = CNT_ZERO;
                  valid_d = 1'b1;
                  state_d = S_DONE;
                  if (b_abs_q == D_ZERO) begin
                     // Divide by zero: LO all ones, HI the original dividend
                     lo_d = D_ONES;
                     hi_d = cond_neg(a_abs_q, sa_q);
                  end else begin
                     lo_d = cond_neg(quo_next_s, sa_q ^ sb_q);
                     hi_d = cond_neg(rem_next_s, sa_q);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_DONE: begin
               if (bus.pipe_adv) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         a_abs_q <= D_ZERO;
         b_abs_q <= D_ZERO;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         rem_q   <= D_ZERO;
         quo_q   <= D_ZERO;
         hi_q    <= D_ZERO;
         lo_q    <= D_ZERO;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_abs_q <= a_abs_d;
         b_abs_q <= b_abs_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         valid_q <= valid_d;
      end
   end

endmodule : mdu_iterative

// File: tb/tb_mdu_iterative.sv
// ----------------------------------------------------------------------------
// tb_mdu_iterative
// Directed self-checking bench for mdu_iterative. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the falling edge.
// ----------------------------------------------------------------------------
module tb_mdu_iterative;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mdu_iterative_if #(.DATA_WIDTH(32)) bus ();

   mdu_iterative #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, measure latency and busy cycles, check result, hold it
   // for 'hold' cycles, then retire it with pipe_adv.
   task automatic run_op(input string tag, input logic is_div, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int hold,
                         input logic scramble);
      int cyc;
      int busy_cnt;
      @(negedge clk);
      bus.op_valid  = 1'b1;
      bus.op_is_div = is_div;
      bus.op_signed = sgn;
      bus.src_a     = a;
      bus.src_b     = b;
      bus.pipe_adv  = 1'b0;
      bus.flush     = 1'b0;
      cyc = 0;
      busy_cnt = 0;
      #1;
      while (bus.res_valid !== 1'b1 && cyc < 100) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(negedge clk);
         if (scramble) begin
            bus.src_a = ~a;
            bus.src_b = a ^ b ^ 32'h5A5A_5A5A;
         end
         #1;
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
      chk({tag, " res_valid"}, {31'd0, bus.res_valid}, 32'd1);
      chk({tag, " hi"}, bus.res_hi, exp_hi);
      chk({tag, " lo"}, bus.res_lo, exp_lo);
      chk({tag, " busy_done"}, {31'd0, bus.busy}, 32'd0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         #1;
         chk({tag, " hold_valid"}, {31'd0, bus.res_valid}, 32'd1);
         chk({tag, " hold_lo"}, bus.res_lo, exp_lo);
      end
      @(negedge clk);
      bus.pipe_adv = 1'b1;
      @(negedge clk);
      bus.pipe_adv = 1'b0;
      bus.op_valid = 1'b0;
      #1;
      chk({tag, " retired_valid"}, {31'd0, bus.res_valid}, 32'd0);
      chk({tag, " retired_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.op_valid  = 1'b0;
      bus.op_is_div = 1'b0;
      bus.op_signed = 1'b0;
      bus.src_a     = 32'd0;
      bus.src_b     = 32'd0;
      bus.flush     = 1'b0;
      bus.pipe_adv  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("reset hi", bus.res_hi, 32'd0);
      chk("reset lo", bus.res_lo, 32'd0);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // MULT -2 * 3 = -6
      run_op("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 2,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 1'b0);
      // DIVU 100 / 7 = 14 r 2, held through a 5-cycle stall
      run_op("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 33,
             32'd2, 32'd14, 5, 1'b0);
      // DIV -7 / 2 = -3 r -1, operands disturbed mid-operation
      run_op("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b1);
      // Signed overflow
      run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
             32'h0000_0000, 32'h8000_0000, 0, 1'b0);
      // Divide by zero, unsigned and signed
      run_op("divu_by0", 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 33,
             32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0);
      run_op("div_by0_neg", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 33,
             32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 1'b0);
      // Widest unsigned product and a signed extreme product
      run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,
             32'hFFFF_FFFE, 32'h0000_0001, 1, 1'b0);
      run_op("mult_min_x2", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0002, 2,
             32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b1);

      // Flush a divide at iteration 10
      @(negedge clk);
      bus.op_valid  = 1'b1;
      bus.op_is_div = 1'b1;
      bus.op_signed = 1'b0;
      bus.src_a     = 32'd1000;
      bus.src_b     = 32'd3;
      repeat (10) @(negedge clk);
      #1;
      chk("flush pre_busy", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      #1;
      chk("flush busy_same_cycle", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      #1;
      chk("flush idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("flush no_valid", {31'd0, bus.res_valid}, 32'd0);
      repeat (35) @(negedge clk);
      #1;
      chk("flush still_no_valid", {31'd0, bus.res_valid}, 32'd0);
      run_op("multu_after_flush", 1'b0, 1'b0, 32'd5, 32'd6, 2,
             32'd0, 32'd30, 0, 1'b0);

      // Reset in the middle of a divide
      @(negedge clk);
      bus.op_valid  = 1'b1;
      bus.op_is_div = 1'b1;
      bus.op_signed = 1'b1;
      bus.src_a     = 32'hFFFF_0000;
      bus.src_b     = 32'd9;
      repeat (6) @(negedge clk);
      rst          = 1'b1;
      bus.op_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("rst hi", bus.res_hi, 32'd0);
      chk("rst lo", bus.res_lo, 32'd0);
      rst = 1'b0;
      run_op("divu_after_rst", 1'b1, 1'b0, 32'd1000, 32'd3, 33,
             32'd1, 32'd333, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mdu_iterative
